// File: rtl/packer_pkg.sv
// Shared types and defaults for the FIFO word packer.
// PACKER_PARITY_EN (optional define) adds the registered out_parity output.
package packer_pkg;
  typedef enum logic {S_LO, S_HI} packer_state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;
endpackage

// File: rtl/packer_out_reg.sv
// Registered valid/ready output slot for packed words.
// PACKER_PARITY_EN (optional define) adds out_parity, loaded with out_data.
module packer_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] out_data,
`ifdef PACKER_PARITY_EN
  output logic         out_parity,
`endif
  output logic         out_valid
);
  // Load wins over handshake so a word arriving on the draining edge is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PACKER_PARITY_EN
  // Even parity tracks out_data, computed from the incoming word.
  always_ff @(posedge clk) begin
    if (reset)     out_parity <= 1'b0;
    else if (load) out_parity <= ^load_data;
  end
`endif
endmodule

// File: rtl/fifo_word_packer.sv
// Pops low/high half-word pairs from the FIFO and emits {high, low} words.
// PACKER_PARITY_EN (optional define) adds the out_parity output.
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    empty,
  input  logic [DATA_WIDTH-1:0]   r_data,
  output logic                    rd,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef PACKER_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [CNT_WIDTH-1:0]    word_cnt
);
  packer_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] lo_reg;
  logic                  ld_lo, ld_word;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LO;
    else       state_q <= state_d;
  end

  // Pop decision: low half pops freely, high half waits for a free output slot.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    ld_lo   = 1'b0;
    ld_word = 1'b0;
    case (state_q)
      S_LO: if (!empty) begin
        rd      = 1'b1;
        ld_lo   = 1'b1;
        state_d = S_HI;
      end
      S_HI: if (!empty && (!out_valid || out_ready)) begin
        rd      = 1'b1;
        ld_word = 1'b1;
        state_d = S_LO;
      end
      default: state_d = S_LO;
    endcase
  end

  // Low half holding register.
  always_ff @(posedge clk) begin
    if (reset)      lo_reg <= '0;
    else if (ld_lo) lo_reg <= r_data;
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                       word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  packer_out_reg #(.W(2*DATA_WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_word),
    .load_data ({r_data, lo_reg}),
    .ready     (out_ready),
    .out_data  (out_data),
`ifdef PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_valid (out_valid)
  );
endmodule
